// File: rtl/store_unit_if.sv
// Request and data-memory write signals for the store unit.
// master = requester/memory side, slave = store_unit.
interface store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  s_sel;
    logic [31:0] StoreAddr;
    logic [31:0] StoreData;
    logic        MemWE;
    logic        mem_ready;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [3:0]  MemBE;
    logic        split;
    logic        done;

    modport master (
        output req_valid, s_sel, StoreAddr, StoreData, mem_ready,
        input  req_ready, MemWE, MemAddr, MemWData, MemBE, split, done
    );

    modport slave (
        input  req_valid, s_sel, StoreAddr, StoreData, mem_ready,
        output req_ready, MemWE, MemAddr, MemWData, MemBE, split, done
    );
endinterface

// File: rtl/store_unit.sv
// Store path: turns a byte/half/word store into one or two word-aligned
// write beats with lane-positioned data and byte enables.
module store_unit (
    input logic         clk,
    input logic         rst_n,
    store_unit_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StBeat0, StBeat1} state_e;

    state_e      state_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_be_q;
    logic [31:0] hi_wdata_q;
    logic [3:0]  hi_be_q;
    logic        split_q;
    logic        done_q;

    logic [1:0]  off;
    logic [3:0]  base_be;
    logic [31:0] data_masked;
    logic [7:0]  be8;
    logic [63:0] d64;

    // Lane placement is computed from the request and captured only at accept,
    // so Mem* outputs never see req_* combinationally.
    always_comb begin
        off = bus.StoreAddr[1:0];
        case (bus.s_sel)
            2'b00: begin
                base_be     = 4'b0001;
                data_masked = {24'd0, bus.StoreData[7:0]};
            end
            2'b01: begin
                base_be     = 4'b0011;
                data_masked = {16'd0, bus.StoreData[15:0]};
            end
            default: begin
                base_be     = 4'b1111;
                data_masked = bus.StoreData;
            end
        endcase
        be8 = {4'b0000, base_be} << off;
        d64 = {32'd0, data_masked} << {off, 3'b000};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_be_q    <= 4'd0;
            hi_wdata_q  <= 32'd0;
            hi_be_q     <= 4'd0;
            split_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        state_q     <= StBeat0;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= {bus.StoreAddr[31:2], 2'b00};
                        mem_wdata_q <= d64[31:0];
                        mem_be_q    <= be8[3:0];
                        hi_wdata_q  <= d64[63:32];
                        hi_be_q     <= be8[7:4];
                        split_q     <= |be8[7:4];
                    end
                end
                StBeat0: begin
                    if (bus.mem_ready) begin
                        if (split_q) begin
                            state_q     <= StBeat1;
                            mem_addr_q  <= mem_addr_q + 32'd4;
                            mem_wdata_q <= hi_wdata_q;
                            mem_be_q    <= hi_be_q;
                        end else begin
                            state_q     <= StIdle;
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= 32'd0;
                            mem_wdata_q <= 32'd0;
                            mem_be_q    <= 4'd0;
                            done_q      <= 1'b1;
                        end
                    end
                end
                StBeat1: begin
                    if (bus.mem_ready) begin
                        state_q     <= StIdle;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= 32'd0;
                        mem_wdata_q <= 32'd0;
                        mem_be_q    <= 4'd0;
                        split_q     <= 1'b0;
                        done_q      <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    mem_we_q <= 1'b0;
                    split_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.MemWE     = mem_we_q;
    assign bus.MemAddr   = mem_addr_q;
    assign bus.MemWData  = mem_wdata_q;
    assign bus.MemBE     = mem_be_q;
    assign bus.split     = split_q;
    assign bus.done      = done_q;
endmodule
